// File: rtl/uart_rx_os16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Purpose  : Oversampling (OVS ticks/bit) UART receiver, 8N1 by default or 8E1
//            when UART_RX_PARITY_EN is defined, with a ready/valid byte output.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_os16 #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16x,
  input  logic       data_i,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       stopbit_error,
  output logic       overrun_error
);

  localparam int            CW       = $clog2(OVS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Reset asserts asynchronously and releases on a clock edge two flops later.
  logic rst_meta;
  logic rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta  <= 1'b0;
      rst_n_int <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_n_int <= rst_meta;
    end
  end

  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= data_i;
      rx_sync <= rx_meta;
    end
  end

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          armed;
  logic          at_last;
  logic          frame_done;
`ifdef UART_RX_PARITY_EN
  logic          parity_bit;
`endif

  assign at_last    = (cnt == CNT_LAST);
  assign frame_done = tick_16x && (state == STOP) && at_last;

  // armed is cleared by a low stop bit so a held-low (break) line cannot
  // start another frame until it has been seen high in IDLE.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      armed      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (tick_16x) begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (at_last) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_last) begin
            cnt        <= '0;
            parity_bit <= rx_sync;
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (at_last) begin
            cnt   <= '0;
            state <= IDLE;
            armed <= rx_sync;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic load_new;
  assign load_new = frame_done && (!data_valid || data_ready);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      stopbit_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= frame_done && data_valid && !data_ready;
      if (load_new) begin
        data_out      <= shreg;
        stopbit_error <= ~rx_sync;
        data_valid    <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      parity_error <= 1'b0;
    end else if (load_new) begin
      parity_error <= ^shreg ^ parity_bit;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_rx_os16: table of frames plus hand-written overrun, glitch,
// mid-frame reset and break sequences, checked through an expected-byte queue.
module tb_uart_rx_os16;

  localparam int OVS  = 16;
  localparam int TDIV = 4;
  localparam int BIT  = OVS * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       tick_16x   = 1'b0;
  logic       data_i     = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       stopbit_error;
  logic       overrun_error;

  uart_rx_os16 #(.OVS(OVS)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_16x     (tick_16x),
    .data_i       (data_i),
    .data_ready   (data_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stopbit_error(stopbit_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  int unsigned div = 0;
  always @(posedge clk) begin
    div      <= (div == TDIV - 1) ? 0 : div + 1;
    tick_16x <= (div == TDIV - 1);
  end

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks     = 0;
  int   failures   = 0;
  int   hs_count   = 0;
  int   ovr_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic perr, input logic serr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.serr = serr;
    sb.push_back(e);
  endtask

  // Monitor samples on the falling edge, half a cycle from the active edge.
  logic       hs_prev = 1'b0;
  logic       hold_v  = 1'b0;
  logic [7:0] hold_data;
  exp_t       got;

  always @(negedge clk) begin
    if (overrun_error) ovr_cycles++;
    if (hs_prev) check("valid_clears_after_accept", {31'd0, data_valid}, 32'd0);
    if (hold_v && data_valid) check("data_out_stable", {24'd0, data_out}, {24'd0, hold_data});
    hs_prev = 1'b0;
    hold_v  = 1'b0;
    if (data_valid && data_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data_out %0h expected no byte", data_out);
      end else begin
        got = sb.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, got.data});
        check("parity_error", {31'd0, parity_error}, {31'd0, got.perr});
        check("stopbit_error", {31'd0, stopbit_error}, {31'd0, got.serr});
      end
      hs_prev = 1'b1;
    end else if (data_valid) begin
      hold_v    = 1'b1;
      hold_data = data_out;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    data_i = v;
    wait_clks(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(pbit);
    drive_bit(stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * BIT) begin
      wait_clks(1);
      n++;
    end
    check(name, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    int ovr_before;

    vecs[0] = '{8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 1'b0, 1'b1};
    vecs[7] = '{8'hC3, 1'b1, 1'b0};

    #2 rst = 1'b0;
    wait_clks(4);
    @(negedge clk);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_parity_error", {31'd0, parity_error}, 32'd0);
    check("reset_stopbit_error", {31'd0, stopbit_error}, 32'd0);
    check("reset_overrun_error", {31'd0, overrun_error}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_clks(10);
    data_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].data, PAR_EN & vecs[i].flip, ~vecs[i].stop);
      send_frame(vecs[i].data, ^vecs[i].data ^ vecs[i].flip, vecs[i].stop);
      wait_drain("table_frame_delivered");
    end

    // Short low glitch must be rejected, and the next frame still received.
    hs_before = hs_count;
    data_i = 1'b0;
    wait_clks((OVS / 4) * TDIV);
    data_i = 1'b1;
    wait_clks(3 * BIT);
    check("glitch_no_frame", hs_count - hs_before, 32'd0);
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    wait_drain("after_glitch_frame");

    // Overrun: second frame arrives while first byte is still unaccepted.
    data_ready = 1'b0;
    ovr_before = ovr_cycles;
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    @(negedge clk);
    check("overrun_pulse_cycles", ovr_cycles - ovr_before, 32'd1);
    check("overrun_keeps_old", {24'd0, data_out}, 32'h11);
    check("overrun_valid_held", {31'd0, data_valid}, 32'd1);
    @(posedge clk);
    #1 data_ready = 1'b1;
    wait_drain("overrun_old_byte");
    wait_clks(2);
    @(negedge clk);
    check("valid_low_after_ready", {31'd0, data_valid}, 32'd0);

    // Reset at data bit 4 of 0x7E: partial frame discarded, 0x81 received.
    wait_clks(1);
    hs_before = hs_count;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b0 : 1'b1);
    data_i = 1'b1;
    rst    = 1'b0;
    #1;
    check("async_reset_data_out", {24'd0, data_out}, 32'd0);
    wait_clks(3);
    rst = 1'b1;
    wait_clks(3 * BIT);
    check("reset_drops_frame", hs_count - hs_before, 32'd0);
    push_exp(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, ^8'h81, 1'b1);
    wait_drain("after_reset_frame");

    // Held-low break line yields exactly one frame with a stop error.
    hs_before = hs_count;
    push_exp(8'h00, 1'b0, 1'b1);
    data_i = 1'b0;
    wait_clks(14 * BIT);
    data_i = 1'b1;
    wait_clks(3 * BIT);
    wait_drain("break_frame");
    check("break_single_frame", hs_count - hs_before, 32'd1);

    check("overrun_total_cycles", ovr_cycles, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
